alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one 32-bit ALU behind a one-entry response register
// ALU_Ctrl map: 00 ADD 01 SUB 02 SLL 03 SLT 04 SLTU 05 XOR 06 SRL 07 SRA 08 OR 09 AND 0A-0F BEQ/BNE/BLT/BGE/BLTU/BGEU 10 LUI

module alu32 (
  input  logic [4:0]  ctrl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        illegal_o
);
  always_comb begin
    result_o  = '0;
    zero_o    = 1'b0;
    illegal_o = 1'b0;
    // Branch compares leave result at zero and report only through zero_o
    case (ctrl_i)
      5'h00: result_o = a_i + b_i;
      5'h01: result_o = a_i - b_i;
      5'h02: result_o = a_i << b_i[4:0];
      5'h03: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      5'h04: result_o = {31'd0, a_i < b_i};
      5'h05: result_o = a_i ^ b_i;
      5'h06: result_o = a_i >> b_i[4:0];
      5'h07: result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      5'h08: result_o = a_i | b_i;
      5'h09: result_o = a_i & b_i;
      5'h0A: zero_o = (a_i == b_i);
      5'h0B: zero_o = (a_i != b_i);
      5'h0C: zero_o = ($signed(a_i) < $signed(b_i));
      5'h0D: zero_o = ($signed(a_i) >= $signed(b_i));
      5'h0E: zero_o = (a_i < b_i);
      5'h0F: zero_o = (a_i >= b_i);
      5'h10: result_o = b_i;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_flag,
  output logic        rsp_illegal,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
);
  logic        valid_q, valid_d;
  logic        id_q, id_d;
  logic [31:0] result_q, result_d;
  logic        flag_q, flag_d;
  logic        illegal_q, illegal_d;
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        last_q, last_d;

  logic        slot_free, sel1, accept0, accept1, accept;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_illegal;

  assign slot_free = !valid_q || rsp_ready;
  // last_q=1 means requester 1 won last, so requester 0 wins the next contention
  assign sel1      = req1_valid && (!req0_valid || ((FAIR != 0) && !last_q));
  assign accept1   = rst_n && slot_free && sel1;
  assign accept0   = rst_n && slot_free && req0_valid && !sel1;
  assign accept    = accept0 || accept1;

  assign req0_ready = accept0;
  assign req1_ready = accept1;

  assign alu_op = sel1 ? req1_op : req0_op;
  assign alu_a  = sel1 ? req1_a  : req0_a;
  assign alu_b  = sel1 ? req1_b  : req0_b;

  alu32 u_alu (
    .ctrl_i    (alu_op),
    .a_i       (alu_a),
    .b_i       (alu_b),
    .result_o  (alu_result),
    .zero_o    (alu_zero),
    .illegal_o (alu_illegal)
  );

  always_comb begin
    valid_d   = valid_q;
    id_d      = id_q;
    result_d  = result_q;
    flag_d    = flag_q;
    illegal_d = illegal_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    last_d    = last_q;
    if (accept) begin
      valid_d   = 1'b1;
      id_d      = accept1;
      result_d  = alu_result;
      flag_d    = alu_zero;
      illegal_d = alu_illegal;
      last_d    = accept1;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
    if (accept0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (accept1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      id_q      <= 1'b0;
      result_q  <= '0;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      last_q    <= 1'b1;
    end else begin
      valid_q   <= valid_d;
      id_q      <= id_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
      illegal_q <= illegal_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      last_q    <= last_d;
    end
  end

  assign rsp_valid   = valid_q;
  assign rsp_id      = id_q;
  assign rsp_result  = result_q;
  assign rsp_flag    = flag_q;
  assign rsp_illegal = illegal_q;
  assign grant_cnt0  = cnt0_q;
  assign grant_cnt1  = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (round-robin DUT plus a fixed-priority twin)
module tb_alu_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rsp_ready;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_flag, rsp_illegal;
  logic [31:0] rsp_result;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_flag, fp_rsp_illegal;
  logic [31:0] fp_rsp_result;
  logic [15:0] fp_grant_cnt0, fp_grant_cnt1;

  alu_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .rsp_illegal(rsp_illegal), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
    .rsp_flag(fp_rsp_flag), .rsp_illegal(fp_rsp_illegal), .grant_cnt0(fp_grant_cnt0), .grant_cnt1(fp_grant_cnt1)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        flag;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   fp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] res, input logic flag, input logic ill);
    exp_t e;
    e.id = id; e.res = res; e.flag = flag; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic drive(input int r, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got response id %0d result 0x%0h expected none", rsp_id, rsp_result);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
        chk("rsp_result", rsp_result, mon_e.res);
        chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, mon_e.flag});
        chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, mon_e.ill});
      end
    end
    if (fp_en && fp_rsp_valid) begin
      chk("fp_rsp_id", {31'd0, fp_rsp_id}, 32'd0);
      chk("fp_rsp_result", fp_rsp_result, 32'd7);
    end
  end

  logic [4:0]  v_op  [4] = '{5'h0A, 5'h0F, 5'h10, 5'h1F};
  logic [31:0] v_a   [4] = '{32'h55, 32'h1, 32'h0, 32'h3};
  logic [31:0] v_b   [4] = '{32'h55, 32'hFFFFFFFF, 32'h12345000, 32'h4};
  logic [31:0] v_res [4] = '{32'h0, 32'h0, 32'h12345000, 32'h0};
  logic        v_flg [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        v_ill [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    drive(0, 1'b1, 5'h00, 32'd0, 32'd0);
    drive(1, 1'b0, 5'h00, 32'd0, 32'd0);
    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_flag", {31'd0, rsp_flag}, 32'd0);
    chk("reset_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
    chk("reset_cnt0", {16'd0, grant_cnt0}, 32'd0);
    chk("reset_cnt1", {16'd0, grant_cnt1}, 32'd0);
    chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    nxt(); rst_n = 1'b1;

    // single ADD
    nxt(); drive(0, 1'b1, 5'h00, 32'd5, 32'd7); push(1'b0, 32'd12, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("add_req1_ready", {31'd0, req1_ready}, 32'd0);
    nxt(); req0_valid = 1'b0;
    @(negedge clk);
    chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_cnt0", {16'd0, grant_cnt0}, 32'd1);

    // contention after reset
    nxt(); rst_n = 1'b0;
    nxt(); rst_n = 1'b1;
    chk("rr_cnt0_cleared", {16'd0, grant_cnt0}, 32'd0);
    drive(0, 1'b1, 5'h01, 32'd10, 32'd3);
    drive(1, 1'b1, 5'h03, 32'hFFFFFFFF, 32'd1);
    push(1'b0, 32'd7, 1'b0, 1'b0); push(1'b1, 32'd1, 1'b0, 1'b0);
    push(1'b0, 32'd7, 1'b0, 1'b0); push(1'b1, 32'd1, 1'b0, 1'b0);
    fp_en = 1'b1;
    repeat (4) nxt();
    req0_valid = 1'b0; req1_valid = 1'b0;
    nxt(); fp_en = 1'b0;
    chk("rr_cnt0", {16'd0, grant_cnt0}, 32'd2);
    chk("rr_cnt1", {16'd0, grant_cnt1}, 32'd2);
    chk("fp_cnt0", {16'd0, fp_grant_cnt0}, 32'd4);

    // backpressure then drain-and-accept
    drive(0, 1'b1, 5'h00, 32'd1, 32'd2); push(1'b0, 32'd3, 1'b0, 1'b0);
    nxt();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    drive(1, 1'b1, 5'h05, 32'hF0, 32'hFF); push(1'b1, 32'h0F, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_result", rsp_result, 32'd3);
      chk("stall_rsp_id", {31'd0, rsp_id}, 32'd0);
    end
    nxt(); rsp_ready = 1'b1;
    @(negedge clk);
    chk("drain_req1_ready", {31'd0, req1_ready}, 32'd1);
    nxt(); req1_valid = 1'b0;
    @(negedge clk);
    chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd1);

    // back-to-back compares, LUI, illegal op
    nxt();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, v_op[i], v_a[i], v_b[i]);
      push(1'b0, v_res[i], v_flg[i], v_ill[i]);
      @(negedge clk);
      chk("b2b_req0_ready", {31'd0, req0_ready}, 32'd1);
      nxt();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    chk("b2b_cnt0", {16'd0, grant_cnt0}, 32'd7);
    chk("b2b_cnt1", {16'd0, grant_cnt1}, 32'd3);

    // saturate grant_cnt0, then reset with a held result
    nxt();
    drive(0, 1'b1, 5'h00, 32'd0, 32'd0);
    repeat (65530) begin push(1'b0, 32'd0, 1'b0, 1'b0); nxt(); end
    drive(0, 1'b1, 5'h00, 32'd9, 32'd9); rsp_ready = 1'b0;
    @(negedge clk);
    chk("sat_cnt0", {16'd0, grant_cnt0}, 32'hFFFF);
    chk("sat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_cnt0", {16'd0, grant_cnt0}, 32'd0);
    chk("async_cnt1", {16'd0, grant_cnt1}, 32'd0);
    chk("async_rsp_result", rsp_result, 32'd0);
    chk("async_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("async_req0_ready", {31'd0, req0_ready}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    drive(0, 1'b1, 5'h00, 32'd9, 32'd9);
    drive(1, 1'b1, 5'h01, 32'd9, 32'd4);
    push(1'b0, 32'd18, 1'b0, 1'b0); push(1'b1, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_reset_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("post_reset_req1_ready", {31'd0, req1_ready}, 32'd0);
    nxt(); nxt();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) nxt();
    chk("sb_empty", sb.size(), 32'd0);
    chk("final_cnt0", {16'd0, grant_cnt0}, 32'd1);
    chk("final_cnt1", {16'd0, grant_cnt1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
